// File: rtl/bitonic_frame_loader_if.sv
// Stream-in / frame-out bus between the serial source, the frame loader and the sort network.
// The slave modport is the loader's view; the master modport is the driver/monitor side.
interface bitonic_frame_loader_if #(
  parameter int unsigned W = 32,
  parameter int unsigned N = 8
) ();
  logic [W-1:0]             in_data;
  logic                     in_valid;
  logic                     in_ready;
  logic                     in_last;
  logic                     in_dir;
  logic [N*W-1:0]           out_data;
  logic                     out_valid;
  logic                     out_ready;
  logic                     out_dir;
  logic [$clog2(N+1)-1:0]   out_count;

  modport slave (
    input  in_data, in_valid, in_last, in_dir, out_ready,
    output in_ready, out_data, out_valid, out_dir, out_count
  );

  modport master (
    output in_data, in_valid, in_last, in_dir, out_ready,
    input  in_ready, out_data, out_valid, out_dir, out_count
  );
endinterface

// File: rtl/bitonic_frame_loader.sv
// Collects a serial word stream into an N-lane frame, pads short frames so the pad sorts to
// the tail for the frame's direction, and holds the frame until the sort network takes it.
module bitonic_frame_loader #(
  parameter int unsigned W = 32,
  parameter int unsigned N = 8
) (
  input logic                  clk,
  input logic                  rst,
  bitonic_frame_loader_if.slave bus
);
  localparam int unsigned CW = $clog2(N + 1);
  localparam int unsigned IW = $clog2(N);

  localparam logic [1:0] ST_FILL = 2'd0;
  localparam logic [1:0] ST_PAD  = 2'd1;
  localparam logic [1:0] ST_HOLD = 2'd2;

  logic [1:0]    r_state;
  logic [IW-1:0] r_idx;
  logic [W-1:0]  r_lane [N];
  logic          r_dir;
  logic [CW-1:0] r_count;
  logic          w_accept;
  logic [N*W-1:0] w_out_data;

  // Gate ready with rst so no word is taken while reset is asserted.
  assign bus.in_ready  = (r_state == ST_FILL) && !rst;
  assign w_accept      = bus.in_valid && bus.in_ready;
  assign bus.out_valid = (r_state == ST_HOLD);
  assign bus.out_dir   = r_dir;
  assign bus.out_count = r_count;
  assign bus.out_data  = w_out_data;

  always_comb begin
    w_out_data = '0;
    for (int k = 0; k < N; k++) begin
      w_out_data[k*W +: W] = r_lane[k];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_FILL;
      r_idx   <= '0;
      r_dir   <= 1'b0;
      r_count <= '0;
      for (int k = 0; k < N; k++) begin
        r_lane[k] <= '0;
      end
    end else begin
      case (r_state)
        ST_FILL: begin
          if (w_accept) begin
            r_lane[r_idx] <= bus.in_data;
            if (r_idx == '0) begin
              r_dir <= bus.in_dir;
            end
            if (r_idx == IW'(N - 1)) begin
              r_state <= ST_HOLD;
              r_count <= CW'(N);
              r_idx   <= '0;
            end else begin
              r_idx <= r_idx + IW'(1);
              if (bus.in_last) begin
                r_state <= ST_PAD;
                r_count <= CW'(r_idx) + CW'(1);
              end
            end
          end
        end
        ST_PAD: begin
          // All-ones pad sorts last ascending; all-zeros sorts last descending.
          for (int k = 0; k < N; k++) begin
            if (CW'(k) >= r_count) begin
              r_lane[k] <= {W{~r_dir}};
            end
          end
          r_state <= ST_HOLD;
        end
        ST_HOLD: begin
          if (bus.out_ready) begin
            r_state <= ST_FILL;
            r_idx   <= '0;
          end
        end
        default: r_state <= ST_FILL;
      endcase
    end
  end
endmodule

// File: tb/tb_bitonic_frame_loader.sv
// Directed and randomized frames checked against a queue-based frame model.
module tb_bitonic_frame_loader;
  localparam int unsigned W  = 32;
  localparam int unsigned N  = 8;
  localparam int unsigned DW = N * W;
  localparam int unsigned CW = $clog2(N + 1);

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_vec = 0;
  int   n_err = 0;

  bitonic_frame_loader_if #(.W(W), .N(N)) bus ();

  bitonic_frame_loader #(.W(W), .N(N)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish (observed timeout, required finish)");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_vec++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Frame model: real words in order, remaining lanes filled with the direction's pad value.
  function automatic logic [DW-1:0] model_frame(input logic [W-1:0] words[$], input bit dir);
    logic [DW-1:0] f;
    f = '0;
    for (int k = 0; k < N; k++) begin
      if (k < words.size()) f[k*W +: W] = words[k];
      else                  f[k*W +: W] = dir ? {W{1'b0}} : {W{1'b1}};
    end
    return f;
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic send_word(input logic [W-1:0] d, input bit last, input bit dir, input bit gaps);
    int t;
    if (gaps) begin
      repeat ($urandom_range(0, 2)) begin
        bus.in_valid  = 1'b0;
        bus.in_data   = $urandom;
        bus.in_last   = 1'($urandom);
        bus.in_dir    = 1'($urandom);
        bus.out_ready = 1'($urandom);
        cyc();
      end
    end
    bus.in_valid  = 1'b1;
    bus.in_data   = d;
    bus.in_last   = last;
    bus.in_dir    = dir;
    bus.out_ready = 1'($urandom);
    t = 0;
    while (!bus.in_ready && t < 50) begin
      cyc();
      t++;
    end
    if (t >= 50) begin
      n_vec++;
      n_err++;
      $display("FAIL in_ready_timeout: observed 0 expected 1");
    end
    cyc();
    bus.in_valid  = 1'b0;
    bus.in_last   = 1'b0;
    bus.out_ready = 1'b0;
  endtask

  task automatic do_frame(input logic [W-1:0] words[$], input bit dir0, input bit last_final,
                          input bit gaps, input int stall);
    logic [DW-1:0] exp;
    int            len;
    len = words.size();
    exp = model_frame(words, dir0);
    for (int i = 0; i < len; i++) begin
      send_word(words[i], (i == len - 1) ? last_final : 1'b0,
                (i == 0) ? dir0 : 1'($urandom), gaps);
    end
    if (len < int'(N)) begin
      check("pad_cycle_valid", DW'(bus.out_valid), DW'(0));
      cyc();
    end
    check("latency_valid", DW'(bus.out_valid), DW'(1));
    check("frame_data", bus.out_data, exp);
    check("frame_dir", DW'(bus.out_dir), DW'(dir0));
    check("frame_count", DW'(bus.out_count), DW'(len));
    check("hold_ready", DW'(bus.in_ready), DW'(0));
    repeat (stall) begin
      bus.in_valid = 1'b1;
      bus.in_data  = $urandom;
      bus.in_last  = 1'($urandom);
      cyc();
      check("stall_ready", DW'(bus.in_ready), DW'(0));
      check("stall_data", bus.out_data, exp);
    end
    bus.in_valid  = 1'b0;
    bus.in_last   = 1'b0;
    bus.out_ready = 1'b1;
    cyc();
    bus.out_ready = 1'b0;
    check("release_valid", DW'(bus.out_valid), DW'(0));
    check("release_ready", DW'(bus.in_ready), DW'(1));
  endtask

  initial begin
    logic [W-1:0] q[$];
    int           len;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.in_last   = 1'b0;
    bus.in_dir    = 1'b0;
    bus.out_ready = 1'b0;
    #1;
    check("rst_ready", DW'(bus.in_ready), DW'(0));
    check("rst_valid", DW'(bus.out_valid), DW'(0));
    check("rst_count", DW'(bus.out_count), DW'(0));
    check("rst_dir", DW'(bus.out_dir), DW'(0));
    check("rst_data", bus.out_data, DW'(0));
    cyc();
    cyc();
    rst = 1'b0;
    #1;
    check("post_rst_ready", DW'(bus.in_ready), DW'(1));

    q = '{32'd7, 32'd3, 32'd9, 32'd1, 32'd0, 32'd5, 32'd2, 32'd8};
    do_frame(q, 1'b0, 1'b0, 1'b0, 0);
    q = '{32'd4, 32'd2, 32'd6};
    do_frame(q, 1'b0, 1'b1, 1'b0, 0);
    q = '{32'd5};
    do_frame(q, 1'b1, 1'b1, 1'b0, 10);
    q = '{32'd11, 32'd12, 32'd13, 32'd14};
    do_frame(q, 1'b1, 1'b1, 1'b1, 2);

    // Reset mid-fill discards the partial frame.
    for (int i = 0; i < 5; i++) send_word($urandom, 1'b0, 1'b1, 1'b0);
    rst = 1'b1;
    #1;
    check("rst_fill_ready", DW'(bus.in_ready), DW'(0));
    check("rst_fill_data", bus.out_data, DW'(0));
    cyc();
    rst = 1'b0;
    #1;
    q = '{};
    for (int i = 0; i < int'(N); i++) q.push_back($urandom);
    do_frame(q, 1'b0, 1'b0, 1'b1, 1);

    // Reset while holding drops out_valid immediately.
    for (int i = 0; i < int'(N); i++) send_word($urandom, 1'b0, 1'b1, 1'b0);
    check("pre_rst_hold_valid", DW'(bus.out_valid), DW'(1));
    rst = 1'b1;
    #1;
    check("rst_hold_valid", DW'(bus.out_valid), DW'(0));
    check("rst_hold_count", DW'(bus.out_count), DW'(0));
    check("rst_hold_dir", DW'(bus.out_dir), DW'(0));
    cyc();
    rst = 1'b0;
    #1;

    for (int f = 0; f < 40; f++) begin
      len = $urandom_range(1, N);
      q = '{};
      for (int i = 0; i < len; i++) q.push_back($urandom);
      do_frame(q, 1'($urandom), (len < int'(N)) ? 1'b1 : 1'($urandom), 1'($urandom),
               $urandom_range(0, 3));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
